// File: rtl/ibuff_ctrl.sv
// ibuff_ctrl: fetch/fill/dequeue sequencing and flush handling for a 4-entry instruction line buffer
module ibuff_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  fill_valid,
  output logic [3:0]            load,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [1:0]            deq_idx,
  output logic [ADDR_WIDTH-1:0] deq_pc,
  output logic                  busy_drain
);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(LINE_BYTES);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [1:0] head, head_n, tail, tail_n;
  logic [2:0] count, count_n, outst, outst_n, drop, drop_n, n;
  logic [ADDR_WIDTH-1:0] fpc, fpc_n, hpc, hpc_n, rpc;
  logic fire, deq;
  assign req_valid = !rst && state == RUN && !flush && ({1'b0, count} + {1'b0, outst} < 4'd4);
  assign load = (!rst && state == RUN && !flush && fill_valid) ? 4'b0001 << tail : 4'b0000;
  assign deq_valid = count != 3'd0 && state == RUN;
  assign req_addr = fpc;
  assign deq_idx = head;
  assign deq_pc = hpc;
  assign busy_drain = state == DRAIN;
  assign fire = req_valid && req_ready;
  assign deq = deq_valid && deq_ready;
  assign rpc = redirect_pc & ~(STEP - 1'b1);
  assign n = outst - 3'(fill_valid);
  always_comb begin
    state_n = state;
    head_n = head;
    tail_n = tail;
    count_n = count;
    outst_n = outst + 3'(fire) - 3'(fill_valid);
    drop_n = drop;
    fpc_n = fire ? fpc + STEP : fpc;
    hpc_n = hpc;
    if (flush) begin
      head_n = '0;
      tail_n = '0;
      count_n = '0;
      fpc_n = rpc;
      hpc_n = rpc;
      outst_n = n;
      drop_n = n;
      state_n = n != 3'd0 ? DRAIN : RUN;
    end else if (state == RUN) begin
      tail_n = tail + 2'(fill_valid);
      head_n = head + 2'(deq);
      count_n = count + 3'(fill_valid) - 3'(deq);
      hpc_n = deq ? hpc + STEP : hpc;
    end else if (fill_valid) begin
      // stale fill: consume its credit, leave the buffer untouched
      drop_n = drop - 3'd1;
      state_n = drop == 3'd1 ? RUN : DRAIN;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      head <= '0;
      tail <= '0;
      count <= '0;
      outst <= '0;
      drop <= '0;
      fpc <= RESET_PC;
      hpc <= RESET_PC;
    end else begin
      state <= state_n;
      head <= head_n;
      tail <= tail_n;
      count <= count_n;
      outst <= outst_n;
      drop <= drop_n;
      fpc <= fpc_n;
      hpc <= hpc_n;
    end
  end
endmodule

// File: tb/tb_ibuff_ctrl.sv
// tb_ibuff_ctrl: directed stimulus with queued expectations checked by a negedge monitor
module tb_ibuff_ctrl;
  logic clk = 0, rst = 1, flush = 0, req_ready = 0, fill_valid = 0, deq_ready = 0;
  logic [31:0] redirect_pc = 0, req_addr, deq_pc;
  logic req_valid, deq_valid, busy_drain;
  logic [3:0] load;
  logic [1:0] deq_idx;
  int errors = 0, checks = 0, tb_out = 0;
  logic [31:0] req_q[$];
  logic [3:0] load_q[$];
  logic [33:0] deq_q[$];
  ibuff_ctrl dut (.clk(clk), .rst(rst), .flush(flush), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .fill_valid(fill_valid), .load(load), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_idx(deq_idx), .deq_pc(deq_pc), .busy_drain(busy_drain));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rst) tb_out = 0;
    else begin
      if (req_valid && req_ready) begin
        if (req_q.size() == 0) chk("req_unexpected", req_addr, 64'hdead);
        else chk("req_addr", req_addr, req_q.pop_front());
      end
      if (load != 4'd0) begin
        if (load_q.size() == 0) chk("load_unexpected", load, 0);
        else chk("load", load, load_q.pop_front());
      end
      if (deq_valid && deq_ready) begin
        if (deq_q.size() == 0) chk("deq_unexpected", {deq_idx, deq_pc}, 64'hdead);
        else chk("deq_idx_pc", {deq_idx, deq_pc}, deq_q.pop_front());
      end
      if (fill_valid) chk("fill_legal", tb_out == 0, 0);
      if (flush) tb_out = (tb_out - int'(fill_valid)) > 0 ? tb_out - int'(fill_valid) : 0;
      else tb_out = tb_out + int'(req_valid && req_ready) - int'(fill_valid);
    end
  end
  initial begin
    #2;
    chk("rst_req_valid", req_valid, 0);
    chk("rst_load", load, 0);
    chk("rst_deq_valid", deq_valid, 0);
    chk("rst_deq_idx", deq_idx, 0);
    chk("rst_deq_pc", deq_pc, 0);
    chk("rst_busy", busy_drain, 0);
    step(); step();
    rst = 0;
    req_ready = 1;
    req_q = '{32'h00, 32'h10, 32'h20, 32'h30};
    repeat (4) step();
    chk("credits_full", req_valid, 0);
    fill_valid = 1;
    load_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    repeat (4) step();
    fill_valid = 0;
    #1;
    chk("full_deq_valid", deq_valid, 1);
    chk("full_deq_idx", deq_idx, 0);
    chk("full_deq_pc", deq_pc, 32'h00);
    chk("full_req_valid", req_valid, 0);
    deq_ready = 1;
    req_q = '{32'h40, 32'h50, 32'h60, 32'h70};
    deq_q = '{{2'd0, 32'h00}, {2'd1, 32'h10}, {2'd2, 32'h20}, {2'd3, 32'h30}, {2'd0, 32'h40}};
    load_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    step(); step();
    fill_valid = 1;
    repeat (3) step();
    req_ready = 0;
    deq_ready = 0;
    step();
    fill_valid = 0;
    deq_ready = 1;
    deq_q = '{{2'd1, 32'h50}, {2'd2, 32'h60}, {2'd3, 32'h70}};
    repeat (3) step();
    deq_ready = 0;
    #1;
    chk("empty_deq_valid", deq_valid, 0);
    req_ready = 1;
    req_q = '{32'h80, 32'h90, 32'ha0};
    repeat (3) step();
    req_ready = 0;
    flush = 1;
    redirect_pc = 32'h1234;
    fill_valid = 1;
    #1;
    chk("flush_load", load, 0);
    chk("flush_req_valid", req_valid, 0);
    step();
    flush = 0;
    chk("drain_busy", busy_drain, 1);
    chk("drain_req_valid", req_valid, 0);
    chk("drain_deq_valid", deq_valid, 0);
    chk("drain_req_addr", req_addr, 32'h1230);
    step();
    chk("drain_busy_drop1", busy_drain, 1);
    step();
    fill_valid = 0;
    #1;
    chk("run_busy", busy_drain, 0);
    chk("run_req_valid", req_valid, 1);
    chk("run_req_addr", req_addr, 32'h1230);
    chk("run_deq_pc", deq_pc, 32'h1230);
    chk("run_deq_idx", deq_idx, 0);
    req_ready = 1;
    req_q = '{32'h1230, 32'h1240};
    step(); step();
    req_ready = 0;
    flush = 1;
    redirect_pc = 32'h5678;
    step();
    flush = 0;
    chk("f2_busy", busy_drain, 1);
    chk("f2_req_addr", req_addr, 32'h5670);
    fill_valid = 1;
    step();
    fill_valid = 0;
    #1;
    chk("f2_busy_drop1", busy_drain, 1);
    flush = 1;
    redirect_pc = 32'h2000;
    step();
    flush = 0;
    chk("f3_busy", busy_drain, 1);
    chk("f3_req_addr", req_addr, 32'h2000);
    fill_valid = 1;
    step();
    fill_valid = 0;
    #1;
    chk("f3_run_busy", busy_drain, 0);
    chk("f3_req_addr_run", req_addr, 32'h2000);
    chk("f3_deq_pc", deq_pc, 32'h2000);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_req_valid", req_valid, 1);
      chk("stall_req_addr", req_addr, 32'h2000);
    end
    req_ready = 1;
    req_q = '{32'h2000};
    step();
    req_ready = 0;
    chk("accept_req_addr", req_addr, 32'h2010);
    fill_valid = 1;
    load_q = '{4'b0001};
    step();
    fill_valid = 0;
    #1;
    chk("pre_rst_deq_valid", deq_valid, 1);
    chk("pre_rst_deq_pc", deq_pc, 32'h2000);
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("arst_req_valid", req_valid, 0);
    chk("arst_load", load, 0);
    chk("arst_deq_valid", deq_valid, 0);
    chk("arst_deq_idx", deq_idx, 0);
    chk("arst_deq_pc", deq_pc, 0);
    chk("arst_busy", busy_drain, 0);
    chk("queues_drained", req_q.size() + load_q.size() + deq_q.size(), 0);
    step();
    rst = 0;
    #1;
    chk("post_rst_req_addr", req_addr, 0);
    chk("post_rst_req_valid", req_valid, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ibuff_ctrl.md
Name: ibuff_ctrl

Overview:
- Sequencing controller for the 4-entry instruction line buffer in the frontend.
- Issues in-order line fetch requests to the I-cache and steers returning fills into buffer slots via a one-hot load vector.
- Presents buffered lines to decode in FIFO order and handles redirect flushes, discarding stale in-flight fills.
- The buffer's own valid bits cannot be cleared except by reset, so this block is the sole authority on slot occupancy.

Parameters:
ADDR_WIDTH, 32, fetch address width in bits
LINE_BYTES, 16, bytes per cache line (power of 2); OFF = log2(LINE_BYTES)
RESET_PC, 32'h0000_0000, fetch address after reset (line aligned)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
flush  input  1  redirect pulse; discards all buffered and in-flight lines
redirect_pc  input  ADDR_WIDTH  new fetch address, valid with flush
req_valid  output  1  line fetch request valid
req_ready  input  1  I-cache accepts request
req_addr  output  ADDR_WIDTH  line-aligned fetch address
fill_valid  input  1  fill for oldest outstanding request; no backpressure
load  output  4  one-hot write enable to buffer slot (combinational from fill_valid)
deq_valid  output  1  head line available to decode
deq_ready  input  1  decode consumes head line
deq_idx  output  2  slot index of the head line (drives the buffer output mux)
deq_pc  output  ADDR_WIDTH  line address of the head line
busy_drain  output  1  high while in DRAIN state

Behaviour:
- State: head[1:0], tail[1:0], count[2:0] (0..4), outst[2:0], drop[2:0], fpc, hpc, FSM {RUN, DRAIN}.
- Reset values: state=RUN, head=tail=count=outst=drop=0, fpc=hpc=RESET_PC.
- Reset outputs: req_valid=0, load=0, deq_valid=0, deq_idx=0, deq_pc=RESET_PC, busy_drain=0.
- req_addr = fpc (always line aligned).
- req_valid = (state==RUN) && !flush && (count+outst < 4). Credits guarantee a free slot for every fill.
- req_addr stays stable while req_valid=1 and req_ready=0.
- Request fire (req_valid && req_ready): fpc += LINE_BYTES (wraps modulo 2^ADDR_WIDTH), outst++.
- Fill in RUN, no flush:
  - load = 1<<tail; tail++ (mod 4); count++; outst--.
  - The data becomes visible in the buffer the next cycle, aligned with the count update.
- Fill in DRAIN, no flush: load=0; drop--; outst--. When drop reaches 0, go to RUN the next cycle.
- deq_valid = (count!=0) && (state==RUN).
- deq_idx = head; deq_pc = hpc.
- Dequeue fire: head++ (mod 4); count--; hpc += LINE_BYTES.
- Simultaneous fill and dequeue: count unchanged; both pointers advance.
- Simultaneous fire and fill: outst unchanged.
- Flush has top priority and overrides req/fill/deq effects that cycle:
  - load=0 and req_valid=0 that cycle.
  - count=0; head=tail=0.
  - fpc=hpc={redirect_pc[ADDR_WIDTH-1:OFF], OFF'b0}.
  - n = outst - fill_valid. If n>0: drop=outst=n, state=DRAIN. Otherwise outst=0, drop=0, state=RUN.
- Flush while in DRAIN: same rule applied to the current outst. Addresses are reloaded.
- busy_drain = (state==DRAIN).
- Fill with outst==0 is illegal. The bench asserts it never occurs.
- Invariant: count+outst <= 4.
- Latency: request-to-load is set by the cache. Fill-to-deq_valid is 1 cycle.

Test Plan:
- Reset, req_ready=1 constant, no fills -> req_addr 0x00,0x10,0x20,0x30 on consecutive cycles; then req_valid=0 with outst=4.
- Return 4 fills, deq_ready=0 -> load sequence 0001,0010,0100,1000; deq_valid=1, deq_idx=0, deq_pc=0x00; req_valid stays 0 (count=4).
- Hold deq_ready=1 with fills streaming -> deq_idx 0,1,2,3,0 and deq_pc 0x00..0x40; simultaneous fill+deq keeps count constant; tail wraps 3->0.
- 3 outstanding, flush with redirect_pc=0x1234 and fill_valid=1 same cycle -> drop=2, DRAIN; next 2 fills give load=0; then RUN; req_addr=0x1230, deq_pc=0x1230.
- Second flush (redirect_pc=0x2000) during DRAIN with drop=1, no fill -> still DRAIN, drop=1, fpc=0x2000; after 1 fill, RUN; req_addr=0x2000.
- req_ready=0 for 5 cycles -> req_valid=1 with req_addr stable; fpc advances only on accept; assert reset mid-stream -> all outputs return to reset values asynchronously.
